// File: rtl/deser8_demux_if.sv
// Serial bit stream in, rebuilt 8-bit word and frame status out.
// The master side drives the serial bits and the slave side receives them.
interface deser8_demux_if;
    logic       din;
    logic       din_valid;
    logic       sof;
    logic [0:7] W;
    logic       word_valid;
    logic       frame_err;
    logic       busy;
    logic [2:0] sel;

    modport master (
        output din, din_valid, sof,
        input  W, word_valid, frame_err, busy, sel
    );

    modport slave (
        input  din, din_valid, sof,
        output W, word_valid, frame_err, busy, sel
    );
endinterface

// File: rtl/deser8_demux.sv
// Purpose: rebuild 8-bit words from a mux-serialized stream, and flag restarted or stalled frames.
// Latency: W and word_valid update on the edge that samples bit 7, which is 8 cycles after sof with no gaps.
// Backpressure: none; one bit is accepted per din_valid cycle, and a gap of TIMEOUT idle cycles aborts the frame.
module deser8_demux #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    deser8_demux_if.slave bus
);

    typedef enum logic {IDLE, RECV} state_t;

    localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT);

    state_t     state, state_nxt;
    logic [2:0] idx, idx_nxt;
    logic [7:0] timer, timer_nxt, timer_inc;
    logic [0:7] shadow, shadow_nxt;
    logic [0:7] word, word_nxt;
    logic       word_valid_q, word_valid_nxt;
    logic       frame_err_q, frame_err_nxt;

    // Saturating increment; the abort normally fires well before the top value.
    assign timer_inc = (timer == 8'hFF) ? timer : timer + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= 3'd0;
            timer        <= 8'd0;
            shadow       <= 8'd0;
            word         <= 8'd0;
            word_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state        <= state_nxt;
            idx          <= idx_nxt;
            timer        <= timer_nxt;
            shadow       <= shadow_nxt;
            word         <= word_nxt;
            word_valid_q <= word_valid_nxt;
            frame_err_q  <= frame_err_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        idx_nxt        = idx;
        timer_nxt      = timer;
        shadow_nxt     = shadow;
        word_nxt       = word;
        word_valid_nxt = 1'b0;
        frame_err_nxt  = 1'b0;

        case (state)
            IDLE: begin
                timer_nxt = 8'd0;
                if (bus.din_valid && bus.sof) begin
                    shadow_nxt[0] = bus.din;
                    idx_nxt       = 3'd1;
                    state_nxt     = RECV;
                end
            end

            RECV: begin
                if (bus.din_valid) begin
                    timer_nxt = 8'd0;
                    if (bus.sof) begin
                        // A restart drops the partial frame and makes this bit index 0.
                        frame_err_nxt = 1'b1;
                        shadow_nxt[0] = bus.din;
                        idx_nxt       = 3'd1;
                    end else begin
                        shadow_nxt[idx] = bus.din;
                        idx_nxt         = idx + 3'd1;
                        if (idx == 3'd7) begin
                            word_nxt       = {shadow[0:6], bus.din};
                            word_valid_nxt = 1'b1;
                            state_nxt      = IDLE;
                        end
                    end
                end else begin
                    timer_nxt = timer_inc;
                    if (timer_inc >= TIMEOUT_L) begin
                        frame_err_nxt = 1'b1;
                        idx_nxt       = 3'd0;
                        timer_nxt     = 8'd0;
                        state_nxt     = IDLE;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
                idx_nxt   = 3'd0;
                timer_nxt = 8'd0;
            end
        endcase
    end

    assign bus.W          = word;
    assign bus.word_valid = word_valid_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.busy       = (state == RECV);
    assign bus.sel        = idx;

endmodule

// File: tb/tb_deser8_demux.sv
// Bench for deser8_demux: directed frames plus a random bit stream, checked every cycle against a queue-based frame model.
module tb_deser8_demux;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    deser8_demux_if bus ();

    deser8_demux #(.TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: the bits of the open frame, plus the last delivered word and the two flags.
    bit         q[$];
    bit         in_frame = 1'b0;
    int         idle     = 0;
    logic [0:7] m_w      = 8'd0;
    bit         m_wv     = 1'b0;
    bit         m_fe     = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model(input bit d, input bit v, input bit s, input bit r);
        m_wv = 1'b0;
        m_fe = 1'b0;
        if (r) begin
            q.delete();
            in_frame = 1'b0;
            idle     = 0;
            m_w      = 8'd0;
        end else if (v && s) begin
            if (in_frame) m_fe = 1'b1;
            q.delete();
            q.push_back(d);
            in_frame = 1'b1;
            idle     = 0;
        end else if (v && in_frame) begin
            q.push_back(d);
            idle = 0;
            if (q.size() == 8) begin
                for (int k = 0; k < 8; k++) m_w[k] = q[k];
                m_wv     = 1'b1;
                in_frame = 1'b0;
                q.delete();
            end
        end else if (!v && in_frame) begin
            idle++;
            if (idle >= TO) begin
                m_fe     = 1'b1;
                in_frame = 1'b0;
                idle     = 0;
                q.delete();
            end
        end
    endtask

    task automatic step(input bit d, input bit v, input bit s, input bit r);
        @(negedge clk);
        bus.din       = d;
        bus.din_valid = v;
        bus.sof       = s;
        rst           = r;
        model(d, v, s, r);
        @(posedge clk);
        #1;
        chk("W",          32'(bus.W),          32'(m_w));
        chk("word_valid", 32'(bus.word_valid), 32'(m_wv));
        chk("frame_err",  32'(bus.frame_err),  32'(m_fe));
        chk("busy",       32'(bus.busy),       32'(in_frame));
        chk("sel",        32'(bus.sel),        in_frame ? 32'(q.size()) : 32'd0);
    endtask

    task automatic send_frame(input logic [0:7] f);
        step(f[0], 1'b1, 1'b1, 1'b0);
        for (int k = 1; k < 8; k++) step(f[k], 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        logic [0:7] f;
        int stall;
        bus.din       = 1'b0;
        bus.din_valid = 1'b0;
        bus.sof       = 1'b0;

        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("rst_W",    32'(bus.W),    32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        step(0, 0, 0, 0);

        // Basic frame: word_valid rises and busy falls on the same cycle, 8 cycles after sof.
        send_frame(8'b00111010);
        chk("basic_W",  32'(bus.W),          32'h3A);
        chk("basic_wv", 32'(bus.word_valid), 32'd1);
        chk("basic_bs", 32'(bus.busy),       32'd0);
        step(0, 0, 0, 0);
        chk("basic_wv_1cyc", 32'(bus.word_valid), 32'd0);

        // Back-to-back frames, the second starting the cycle after bit 7.
        send_frame(8'b11110000);
        chk("b2b_W1", 32'(bus.W), 32'hF0);
        send_frame(8'b10101010);
        chk("b2b_W2",  32'(bus.W),          32'hAA);
        chk("b2b_wv2", 32'(bus.word_valid), 32'd1);

        // Restart after 4 bits: the old W is held until the new frame completes.
        send_frame(8'b10101010);
        step(1, 1, 1, 0);
        for (int k = 0; k < 3; k++) step(0, 1, 0, 0);
        step(1, 1, 1, 0);
        chk("rs_fe",   32'(bus.frame_err), 32'd1);
        chk("rs_hold", 32'(bus.W),         32'hAA);
        f = 8'b10000001;
        for (int k = 1; k < 8; k++) step(f[k], 1'b1, 1'b0, 1'b0);
        chk("rs_W", 32'(bus.W), 32'h81);

        // Timeout after the 4th idle cycle of a frame.
        step(1, 1, 1, 0);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0);
        chk("to_pre_fe", 32'(bus.frame_err), 32'd0);
        step(0, 0, 0, 0);
        chk("to_fe",   32'(bus.frame_err), 32'd1);
        chk("to_busy", 32'(bus.busy),      32'd0);
        chk("to_W",    32'(bus.W),         32'h81);

        // A 3-cycle gap inside a frame is tolerated.
        f = 8'b01100110;
        step(f[0], 1, 1, 0);
        for (int k = 1; k < 4; k++) step(f[k], 1, 0, 0);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0);
        for (int k = 4; k < 8; k++) step(f[k], 1, 0, 0);
        chk("gap_W", 32'(bus.W), 32'h66);

        // A stray bit in IDLE is ignored; reset after 5 bits clears everything silently.
        step(1, 1, 0, 0);
        chk("stray_busy", 32'(bus.busy), 32'd0);
        step(1, 1, 1, 0);
        for (int k = 0; k < 4; k++) step(1, 1, 0, 0);
        step(1, 1, 0, 1);
        chk("mrst_fe", 32'(bus.frame_err), 32'd0);
        chk("mrst_W",  32'(bus.W),         32'd0);
        send_frame(8'b01010101);
        chk("post_rst_W", 32'(bus.W), 32'h55);

        // Random stream with sof restarts, stalls long enough to time out, and rare resets.
        stall = 0;
        for (int c = 0; c < 3000; c++) begin
            bit v, s, d, r;
            if (stall == 0 && $urandom_range(0, 39) == 0) stall = $urandom_range(1, 6);
            d = 1'($urandom);
            s = ($urandom_range(0, 9) == 0);
            r = ($urandom_range(0, 299) == 0);
            if (stall > 0) begin
                v = 1'b0;
                stall--;
            end else begin
                v = ($urandom_range(0, 4) != 0);
            end
            step(d, v, s, r);
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
